// File: rtl/mem_port2_arbiter.sv
// Port-2 arbiter for OTTER_mem_byte: programmer writes take fixed priority, CPU is guaranteed a slot.
// Optional ARB_PERF_CNT_EN adds a saturating count of CPU stall cycles on CONFLICT_CNT.
module mem_port2_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_STALL,
    output logic [31:0] CPU_DOUT,
    output logic        CPU_RVALID,
    input  logic        PRG_WE,
    input  logic [31:0] PRG_ADDR,
    input  logic [31:0] PRG_DATA,
    output logic        PRG_GNT,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,
    output logic [15:0] CONFLICT_CNT
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [7:0] LIMIT = STARVE_LIMIT[7:0];

    state_t     state, next_state;
    logic [7:0] starve_cnt, starve_next;
    logic       starve_hit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_next;
        end
    end

    assign starve_hit = CPU_REQ && (starve_cnt == LIMIT);

    // Outputs are combinational, so they are gated by reset to read 0 immediately.
    always_comb begin
        next_state  = state;
        CPU_GNT     = 1'b0;
        PRG_GNT     = 1'b0;
        CPU_RVALID  = 1'b0;
        CPU_DOUT    = '0;
        MEM_READ2   = 1'b0;
        MEM_WRITE2  = 1'b0;
        MEM_ADDR2   = CPU_ADDR;
        MEM_DIN2    = CPU_DIN;
        MEM_SIZE    = CPU_SIZE;
        MEM_SIGN    = CPU_SIGN;
        if (!RST) begin
            MEM_ADDR2 = '0;
            MEM_DIN2  = '0;
            MEM_SIZE  = '0;
            MEM_SIGN  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PRG_WE && !starve_hit) begin
                        PRG_GNT    = 1'b1;
                        MEM_WRITE2 = 1'b1;
                        MEM_ADDR2  = PRG_ADDR;
                        MEM_DIN2   = PRG_DATA;
                        MEM_SIZE   = 2'b10;
                        MEM_SIGN   = 1'b0;
                    end else if (CPU_REQ) begin
                        CPU_GNT = 1'b1;
                        if (CPU_WE) begin
                            MEM_WRITE2 = 1'b1;
                        end else begin
                            MEM_READ2  = 1'b1;
                            next_state = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    CPU_RVALID = 1'b1;
                    CPU_DOUT   = MEM_DOUT2;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (!CPU_REQ || CPU_GNT) begin
            starve_next = '0;
        end else if (PRG_GNT && (starve_cnt != LIMIT)) begin
            starve_next = starve_cnt + 8'd1;
        end
    end

    assign CPU_STALL = RST && CPU_REQ && !CPU_GNT;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            conflict_cnt <= '0;
        end else if (CPU_STALL && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign CONFLICT_CNT = conflict_cnt;
`else
    assign CONFLICT_CNT = '0;
`endif

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Scoreboard bench for mem_port2_arbiter: driver queues hand-computed expectations, monitor checks them.
module tb_mem_port2_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_REQ, CPU_WE, CPU_SIGN, PRG_WE;
    logic [31:0] CPU_ADDR, CPU_DIN, PRG_ADDR, PRG_DATA, MEM_DOUT2;
    logic [1:0]  CPU_SIZE;
    logic        CPU_GNT, CPU_STALL, CPU_RVALID, PRG_GNT;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [31:0] CPU_DOUT, MEM_ADDR2, MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic [15:0] CONFLICT_CNT;

    mem_port2_arbiter #(.STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
        .CPU_GNT(CPU_GNT), .CPU_STALL(CPU_STALL), .CPU_DOUT(CPU_DOUT), .CPU_RVALID(CPU_RVALID),
        .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_DATA(PRG_DATA), .PRG_GNT(PRG_GNT),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2),
        .CONFLICT_CNT(CONFLICT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n, req, we, sign, pwe;
        logic [31:0] addr, din, paddr, pdata, mdout;
        logic [1:0]  size;
    } stim_t;

    typedef struct {
        int          cyc;
        string       name;
        logic        cg, pg, st, rv, rd, wr, msign;
        logic [31:0] dout, maddr, mdin;
        logic [1:0]  msize;
        logic [15:0] conf;
    } exp_t;

    exp_t        q[$];
    int          cycle_no = 0;
    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_conf = '0;

    initial forever begin
        @(posedge CLK);
        cycle_no++;
    end

    function automatic stim_t mk(input logic rst_n, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] din,
                                 input logic [1:0] size, input logic sign, input logic pwe,
                                 input logic [31:0] paddr, input logic [31:0] pdata,
                                 input logic [31:0] mdout);
        stim_t s;
        s.rst_n = rst_n; s.req = req; s.we = we; s.addr = addr; s.din = din;
        s.size = size; s.sign = sign; s.pwe = pwe; s.paddr = paddr; s.pdata = pdata;
        s.mdout = mdout;
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be in that cycle.
    task automatic step(input stim_t s, input logic cg, input logic pg, input logic st,
                        input logic rv, input logic [31:0] dout, input string name);
        exp_t e;
        @(posedge CLK);
        #1;
        RST = s.rst_n; CPU_REQ = s.req; CPU_WE = s.we; CPU_ADDR = s.addr; CPU_DIN = s.din;
        CPU_SIZE = s.size; CPU_SIGN = s.sign; PRG_WE = s.pwe; PRG_ADDR = s.paddr;
        PRG_DATA = s.pdata; MEM_DOUT2 = s.mdout;
        e.cyc = cycle_no; e.name = name;
        e.cg = cg; e.pg = pg; e.st = st; e.rv = rv; e.dout = dout;
        e.rd = 1'b0; e.wr = 1'b0;
        if (!s.rst_n) begin
            e.maddr = '0; e.mdin = '0; e.msize = '0; e.msign = 1'b0;
        end else if (pg) begin
            e.wr = 1'b1; e.maddr = s.paddr; e.mdin = s.pdata; e.msize = 2'b10; e.msign = 1'b0;
        end else begin
            e.maddr = s.addr; e.mdin = s.din; e.msize = s.size; e.msign = s.sign;
            if (cg) begin
                e.wr = s.we;
                e.rd = ~s.we;
            end
        end
`ifdef ARB_PERF_CNT_EN
        if (!s.rst_n) exp_conf = '0;
        e.conf = exp_conf;
        if (s.rst_n && st && exp_conf != 16'hFFFF) exp_conf++;
`else
        e.conf = '0;
`endif
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(negedge CLK);
            if (q.size() > 0 && q[0].cyc == cycle_no) begin
                e = q.pop_front();
                checks++;
                ok = (CPU_GNT === e.cg) && (PRG_GNT === e.pg) && (CPU_STALL === e.st) &&
                     (CPU_RVALID === e.rv) && (CPU_DOUT === e.dout) && (MEM_READ2 === e.rd) &&
                     (MEM_WRITE2 === e.wr) && (MEM_ADDR2 === e.maddr) && (MEM_DIN2 === e.mdin) &&
                     (MEM_SIZE === e.msize) && (MEM_SIGN === e.msign) && (CONFLICT_CNT === e.conf);
                if (ok) passes++;
                else $display("FAIL %s cyc=%0d got cg=%b pg=%b st=%b rv=%b dout=%h rd=%b wr=%b addr=%h din=%h sz=%b sg=%b cnt=%0d want cg=%b pg=%b st=%b rv=%b dout=%h rd=%b wr=%b addr=%h din=%h sz=%b sg=%b cnt=%0d",
                              e.name, cycle_no, CPU_GNT, PRG_GNT, CPU_STALL, CPU_RVALID, CPU_DOUT,
                              MEM_READ2, MEM_WRITE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, CONFLICT_CNT,
                              e.cg, e.pg, e.st, e.rv, e.dout, e.rd, e.wr, e.maddr, e.mdin, e.msize, e.msign, e.conf);
            end else if (CPU_GNT || PRG_GNT || CPU_STALL || CPU_RVALID || MEM_READ2 || MEM_WRITE2) begin
                checks++;
                $display("FAIL unexpected_output cyc=%0d got cg=%b pg=%b st=%b rv=%b rd=%b wr=%b want no activity",
                         cycle_no, CPU_GNT, PRG_GNT, CPU_STALL, CPU_RVALID, MEM_READ2, MEM_WRITE2);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] GARB = 32'h5555_AAAA;

    initial begin : driver
        RST = 1'b0; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
        CPU_SIZE = '0; CPU_SIGN = 1'b0; PRG_WE = 1'b0; PRG_ADDR = '0; PRG_DATA = '0;
        MEM_DOUT2 = '0;

        step(mk(0, 1, 0, 32'h44, 32'h1, 2'b10, 0, 1, 32'h8, 32'h9, GARB), 0, 0, 0, 0, 0, "reset_hold");
        step(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, GARB), 0, 0, 0, 0, 0, "reset_hold2");
        step(mk(1, 0, 0, 32'h100, 32'h200, 2'b01, 1, 0, 0, 0, GARB), 0, 0, 0, 0, 0, "idle_passthru");

        // CPU write, then back-to-back reads.
        step(mk(1, 1, 1, 32'h2000, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "cpu_write");
        step(mk(1, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "cpu_read_n");
        step(mk(1, 1, 0, 32'h2004, 0, 2'b10, 1, 0, 0, 0, 32'hDEAD_BEEF), 0, 0, 1, 1, 32'hDEAD_BEEF, "read_data_n1");
        step(mk(1, 1, 0, 32'h2004, 0, 2'b10, 1, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "b2b_read_n2");
        step(mk(1, 0, 0, 32'h0, 0, 2'b00, 0, 1, 32'h20, 32'h77, 32'h0BAD_F00D), 0, 0, 0, 1, 32'h0BAD_F00D, "rdwait_blocks_prg");
        step(mk(1, 0, 0, 32'h0, 0, 2'b00, 0, 1, 32'h20, 32'h77, GARB), 0, 1, 0, 0, 0, "prg_after_rdwait");

        // PRG writes ignore CPU size/sign; continuous PRG with CPU idle.
        step(mk(1, 0, 0, 32'h0, 0, 2'b00, 1, 1, 32'h10, 32'h1234_5678, GARB), 0, 1, 0, 0, 0, "prg_word_force");
        step(mk(1, 0, 0, 32'h0, 0, 2'b00, 1, 1, 32'h14, 32'h9ABC_DEF0, GARB), 0, 1, 0, 0, 0, "prg_every_cycle");

        // Starvation limiter: 8 PRG grants, forced CPU grant, PRG resumes.
        for (int i = 0; i < 8; i++)
            step(mk(1, 1, 1, 32'h3000, 32'hCAFE_0000, 2'b10, 0, 1, 32'h400 + 32'(i * 4), 32'(i), GARB),
                 0, 1, 1, 0, 0, "starve_prg");
        step(mk(1, 1, 1, 32'h3000, 32'hCAFE_0000, 2'b10, 0, 1, 32'h420, 32'h8, GARB), 1, 0, 0, 0, 0, "starve_cpu_forced");
        step(mk(1, 1, 1, 32'h3004, 32'hCAFE_0001, 2'b10, 0, 1, 32'h424, 32'h9, GARB), 0, 1, 1, 0, 0, "prg_resumes");
        step(mk(1, 1, 1, 32'h3004, 32'hCAFE_0001, 2'b10, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "cpu_after_prg");

        // Reset asserted in the RD_WAIT cycle drops the pending read.
        step(mk(1, 1, 0, 32'h40, 0, 2'b10, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "read_before_rst");
        step(mk(0, 1, 0, 32'h40, 0, 2'b10, 0, 1, 32'h50, 32'h5, 32'h1111_2222), 0, 0, 0, 0, 0, "rst_in_rdwait");
        step(mk(1, 0, 0, 32'h40, 0, 2'b10, 0, 0, 0, 0, 32'h1111_2222), 0, 0, 0, 0, 0, "no_rvalid_after_rst");
        step(mk(1, 1, 1, 32'h60, 32'h66, 2'b00, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "idle_after_rst");

        // Five stall cycles after reset: read then four PRG-vs-CPU conflicts.
        step(mk(1, 1, 0, 32'h70, 0, 2'b10, 0, 0, 0, 0, GARB), 1, 0, 0, 0, 0, "read_pre_stall");
        step(mk(1, 1, 0, 32'h74, 0, 2'b10, 0, 1, 32'h80, 32'h1, 32'h0000_0074), 0, 0, 1, 1, 32'h0000_0074, "stall_rdwait");
        for (int i = 0; i < 4; i++)
            step(mk(1, 1, 0, 32'h74, 0, 2'b10, 0, 1, 32'h80, 32'h1, GARB), 0, 1, 1, 0, 0, "stall_prg");
        step(mk(1, 0, 0, 32'h74, 0, 2'b10, 0, 0, 0, 0, GARB), 0, 0, 0, 0, 0, "conflict_total");

        repeat (2) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
